// File: rtl/data_producer.sv
// Dummy AXI-Stream source: on start, emits packet_count packets of PKT_BEATS beats
// carrying a replicated 32-bit sequence, with optional valid throttling and inter-packet gaps.
module data_producer #(
  parameter int DW            = 128,
  parameter int PKT_BEATS     = 16,
  parameter int VALID_CYCLES  = 0,
  parameter int NVALID_CYCLES = 0,
  parameter int IPG_CYCLES    = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [31:0]   packet_count,
  output logic          busy,
  output logic          done,
  output logic [31:0]   packets_sent,
  output logic [DW-1:0] AXIS_TX_TDATA,
  output logic [4:0]    AXIS_TX_TUSER,
  output logic          AXIS_TX_TLAST,
  output logic          AXIS_TX_TVALID,
  input  logic          AXIS_TX_TREADY,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, THROTTLE = 2'd2, IPG = 2'd3} state_t;

  localparam logic [15:0] LAST_BEAT   = 16'(PKT_BEATS - 1);
  localparam logic [31:0] VALID_LEN   = 32'(VALID_CYCLES);
  localparam logic [31:0] NVALID_LEN  = 32'(NVALID_CYCLES);
  localparam logic [31:0] IPG_LEN     = 32'(IPG_CYCLES);
  localparam bit          THROTTLE_ON = (VALID_CYCLES != 0) && (NVALID_CYCLES != 0);
  localparam bit          IPG_ON      = (IPG_CYCLES != 0);

  state_t      state;
  logic [31:0] seq;
  logic [15:0] beat_idx;
  logic [31:0] pkt_idx;
  logic [31:0] pkt_total;
  logic [31:0] thr_cnt;
  logic [31:0] gap_cnt;
  logic        tvalid;
  logic        tlast;

  // Handshake: a beat transfers on any cycle with TVALID=1 and TREADY=1; once TVALID
  // rises it and TDATA/TUSER/TLAST hold until that transfer happens.
  logic        accept;
  logic [31:0] thr_inc;
  logic        final_pkt;
  logic        go_throttle;

  assign accept      = tvalid & AXIS_TX_TREADY;
  assign thr_inc     = thr_cnt + 32'd1;
  assign final_pkt   = (pkt_idx + 32'd1) == pkt_total;
  assign go_throttle = THROTTLE_ON && (thr_inc == VALID_LEN);

  assign AXIS_TX_TDATA  = {(DW/32){seq}};
  assign AXIS_TX_TUSER  = pkt_idx[4:0];
  assign AXIS_TX_TLAST  = tlast;
  assign AXIS_TX_TVALID = tvalid;
  assign fsm_state      = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      seq          <= '0;
      beat_idx     <= '0;
      pkt_idx      <= '0;
      pkt_total    <= '0;
      thr_cnt      <= '0;
      gap_cnt      <= '0;
      tvalid       <= 1'b0;
      tlast        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      packets_sent <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            seq          <= '0;
            beat_idx     <= '0;
            pkt_idx      <= '0;
            packets_sent <= '0;
            thr_cnt      <= '0;
            tlast        <= (LAST_BEAT == 16'd0);
            if (packet_count != 32'd0) begin
              pkt_total <= packet_count;
              state     <= SEND;
              tvalid    <= 1'b1;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (accept) begin
            seq <= seq + 32'd1;
            if (tlast && final_pkt) begin
              packets_sent <= packets_sent + 32'd1;
              beat_idx     <= '0;
              state        <= IDLE;
              tvalid       <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end else begin
              if (tlast) begin
                packets_sent <= packets_sent + 32'd1;
                pkt_idx      <= pkt_idx + 32'd1;
                beat_idx     <= '0;
                tlast        <= (LAST_BEAT == 16'd0);
              end else begin
                beat_idx <= beat_idx + 16'd1;
                tlast    <= (beat_idx + 16'd1) == LAST_BEAT;
              end
              // An inter-packet gap absorbs any throttle gap due on the same beat.
              if (tlast && IPG_ON) begin
                state   <= IPG;
                tvalid  <= 1'b0;
                thr_cnt <= '0;
                gap_cnt <= IPG_LEN - 32'd1;
              end else if (go_throttle) begin
                state   <= THROTTLE;
                tvalid  <= 1'b0;
                thr_cnt <= '0;
                gap_cnt <= NVALID_LEN - 32'd1;
              end else begin
                thr_cnt <= thr_inc;
              end
            end
          end
        end
        THROTTLE, IPG: begin
          if (gap_cnt == 32'd0) begin
            state  <= SEND;
            tvalid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
